apb_master_arb: RTL

Round-robin APB3 master that shares one APB slave (the 32-word memory slave, `ADDR`=5) among `NUM_REQ` local requesters. Each requester posts a single read or write via a level request. The block arbitrates, runs the IDLE/SETUP/ACCESS protocol including pready wait states, and returns prdata/pslverr with a one-cycle done pulse. It sits between the bus-side agents and the slave's psel/penable/paddr port.

---
 rtl/apb_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/apb_master_arb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// =============================================================================
// Package : apb_arb_pkg
// Shared state encoding and default widths for the round-robin APB3 master.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR       = 5;
  localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// =============================================================================
// Module : rr_arbiter
// Combinational one-hot round-robin pick from request, mask and start pointer.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  logic [N-1:0]   w_elig;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;

  assign w_elig = req_i & ~mask_i;
  // Rotate so bit 0 is the requester at the pointer, then take the first set bit.
  assign w_dbl  = {w_elig, w_elig} >> ptr_i;
  assign w_rot  = w_dbl[N-1:0];

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
  end

  assign valid_o = |w_elig;
  assign w_sum   = {1'b0, w_off} + {1'b0, ptr_i};
  assign idx_o   = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : w_sum[PW-1:0];
  assign gnt_o   = valid_o ? (N'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/apb_master_arb.sv
// =============================================================================
// Module : apb_master_arb
// Round-robin APB3 master sharing one slave among NUM_REQ requesters.
// Optional ACCESS timeout: define APB_ARB_TIMEOUT_EN.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR       = DEF_ADDR,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR-1:0]              paddr,
  output logic [DATA_WIDTH-1:0]        pwdata,
  input  logic                         pready,
  input  logic                         pslverr,
  input  logic [DATA_WIDTH-1:0]        prdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      mask_q, mask_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR-1:0]         paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;

  logic                    w_timeout;
  logic                    w_complete;
  logic                    w_arb_en;
  logic [NUM_REQ-1:0]      w_arb_mask;
  logic [NUM_REQ-1:0]      w_win_gnt;
  logic                    w_win_valid;
  logic [PW-1:0]           w_win_idx;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  assign w_timeout = (state_q == ST_ACCESS) && !pready && (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP)       cnt_d = '0;
    else if (state_q == ST_ACCESS) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
`endif

  assign w_complete = (state_q == ST_ACCESS) && (pready || w_timeout);
  assign w_arb_en   = (state_q == ST_IDLE) || w_complete;
  // The owner finishing now stays masked on this edge and on the next one.
  assign w_arb_mask = w_complete ? gnt_q : mask_q;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .req_i   (req),
    .mask_i  (w_arb_mask),
    .ptr_i   (ptr_q),
    .gnt_o   (w_win_gnt),
    .valid_o (w_win_valid),
    .idx_o   (w_win_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mask_d    = '0;
    gnt_d     = gnt_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (w_complete) begin
          done_d  = gnt_q;
          mask_d  = gnt_q;
          gnt_d   = '0;
          rdata_d = (pready && !pwrite_q) ? prdata : '0;
          err_d   = pready ? pslverr : 1'b1;
        end
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    if (w_arb_en) begin
      if (w_win_valid) begin
        state_d   = ST_SETUP;
        psel_d    = 1'b1;
        penable_d = 1'b0;
        gnt_d     = w_win_gnt;
        ptr_d     = (w_win_idx == PW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        pwrite_d  = req_write[w_win_idx];
        paddr_d   = req_addr[w_win_idx*ADDR +: ADDR];
        pwdata_d  = req_wdata[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        gnt_d     = '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      mask_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mask_q    <= mask_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

`default_nettype wire
